// File: rtl/amp_array_pkg.sv
// amp_array_pkg: mode encoding and the fixed-point round-and-clamp helpers shared by the amplifier array.
package amp_array_pkg;
  typedef enum logic {AMP = 1'b0, GYR = 1'b1} mode_e;

  function automatic longint round_shift(longint p, int frac);
    return (p + (longint'(1) <<< (frac - 1))) >>> frac;
  endfunction

  function automatic logic out_of_range(longint p, int w, int frac);
    longint r = round_shift(p, frac);
    return r > (longint'(1) <<< (w - 1)) - 1 || r < -(longint'(1) <<< (w - 1));
  endfunction

  function automatic longint round_sat(longint p, int w, int frac);
    longint r = round_shift(p, frac);
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -(longint'(1) <<< (w - 1));
    return r > hi ? hi : (r < lo ? lo : r);
  endfunction
endpackage

// File: rtl/amp_array_sat.sv
// amp_array_sat: rounds one channel's full-width product half-up and clamps it to a W-bit sample.
module amp_array_sat
  import amp_array_pkg::*;
#(
  parameter int W    = 16,
  parameter int GW   = 8,
  parameter int FRAC = 4
) (
  input  logic signed [W+GW:0] prod,
  output logic signed [W-1:0]  y,
  output logic                 sat
);
  assign y   = W'(round_sat(longint'(prod), W, FRAC));
  assign sat = out_of_range(longint'(prod), W, FRAC);
endmodule

// File: rtl/amp_array.sv
// amp_array: per-channel gain (AMP) or pairwise gyrator (GYR) stage with a two-deep
// stallable pipeline: products registered first, rounded/saturated samples second.
module amp_array
  import amp_array_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int W    = 16,
  parameter int GW   = 8,
  parameter int FRAC = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [NCH*W-1:0]           s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [NCH*W-1:0]           m_data,
  output logic [NCH-1:0]             m_sat,
  input  logic                       cfg_we,
  input  logic [$clog2(NCH)-1:0]     cfg_ch,
  input  logic [GW-1:0]              cfg_gain,
  input  logic                       mode
);
  localparam int PW = W + GW + 1;
  if (NCH < 2 || NCH % 2 != 0) begin : g_bad_nch
    $error("amp_array: NCH must be even and at least 2");
  end
  if (FRAC < 1 || FRAC >= GW) begin : g_bad_frac
    $error("amp_array: FRAC must satisfy 1 <= FRAC < GW");
  end
  logic signed [GW-1:0] gain [NCH];
  logic signed [PW-1:0] prod_c [NCH];
  logic signed [PW-1:0] prod_q [NCH];
  logic [NCH*W-1:0]     y_c;
  logic [NCH-1:0]       sat_c;
  logic                 v1;
  logic                 en;
  mode_e                md;
  assign en      = !m_valid || m_ready;
  assign s_ready = en;
  assign md      = mode_e'(mode);
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam int P = c ^ 1;
    logic signed [PW-1:0] g_x, x_s, p;
    assign g_x = PW'(gain[c]);
    assign x_s = PW'($signed(md == GYR ? s_data[P*W +: W] : s_data[c*W +: W]));
    assign p   = g_x * x_s;
    // negate the widened product so -(-2^(W-1)) stays representable
    assign prod_c[c] = (md == GYR && c % 2 == 0) ? -p : p;
    amp_array_sat #(.W(W), .GW(GW), .FRAC(FRAC)) u_sat (
      .prod(prod_q[c]),
      .y   (y_c[c*W +: W]),
      .sat (sat_c[c])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) gain[i] <= GW'(1 << FRAC);
    end else if (cfg_we) begin
      gain[cfg_ch] <= cfg_gain;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sat   <= '0;
      for (int i = 0; i < NCH; i++) prod_q[i] <= '0;
    end else if (en) begin
      v1      <= s_valid;
      m_valid <= v1;
      if (s_valid) prod_q <= prod_c;
      if (v1) begin
        m_data <= y_c;
        m_sat  <= sat_c;
      end
    end
  end
endmodule

// File: tb/tb_amp_array.sv
// tb_amp_array: randomized and directed scoreboard bench for amp_array against an arithmetic reference model.
module tb_amp_array;
  localparam int NCH = 4, W = 16, GW = 8, FRAC = 4;
  typedef struct packed {logic [NCH*W-1:0] d; logic [NCH-1:0] s;} exp_t;
  logic clk = 0, rst_n = 0, s_valid = 0, s_ready, m_valid, m_ready = 1, cfg_we = 0, mode = 0;
  logic [NCH*W-1:0] s_data = '0, m_data;
  logic [NCH-1:0] m_sat;
  logic [1:0] cfg_ch = '0;
  logic [GW-1:0] cfg_gain = '0;
  amp_array #(.NCH(NCH), .W(W), .GW(GW), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sat(m_sat),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_gain(cfg_gain), .mode(mode)
  );
  always #5 clk = ~clk;
  exp_t q[$];
  logic signed [GW-1:0] mgain [NCH];
  int n_cmp = 0, n_err = 0;
  bit ovr_en = 0, acc = 0;
  exp_t ovr;

  task automatic chk(string nm, logic [127:0] got, logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  function automatic exp_t model(logic [NCH*W-1:0] d, logic md);
    exp_t e;
    longint hi = 32767, lo = -32768, sc = 1 << FRAC;
    for (int c = 0; c < NCH; c++) begin
      int src = md ? (c % 2 == 0 ? c + 1 : c - 1) : c;
      longint x = signed'(d[src*W +: W]);
      longint g = mgain[c];
      longint p = g * x;
      longint r, v;
      if (md && c % 2 == 0) p = -p;
      r = p + sc / 2;
      v = r / sc;
      if (r < 0 && r % sc != 0) v = v - 1;
      e.s[c] = (v > hi) || (v < lo);
      v = v > hi ? hi : (v < lo ? lo : v);
      e.d[c*W +: W] = W'(v);
    end
    return e;
  endfunction

  function automatic logic [NCH*W-1:0] pk(int a, int b, int c, int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic tick(bit sv, logic [NCH*W-1:0] d, bit md, bit we, int ch, int g, bit mr);
    @(negedge clk);
    s_valid = sv; s_data = d; mode = md; cfg_we = we; cfg_ch = 2'(ch); cfg_gain = 8'(g); m_ready = mr;
    #1;
    if (m_valid && !m_ready) chk("stall_sready", 128'(s_ready), 0);
    acc = s_valid && s_ready;
    if (acc) q.push_back(ovr_en ? ovr : model(d, md));
    if (we) mgain[ch] = 8'(g);
  endtask

  task automatic send(logic [NCH*W-1:0] d, bit md, bit we, int ch, int g, bit e_en, exp_t e);
    ovr_en = e_en; ovr = e;
    for (int i = 0; i < 20; i++) begin
      tick(1, d, md, we, ch, g, 1);
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 128'(acc), 1);
    ovr_en = 0;
  endtask

  task automatic cfg(int ch, int g);
    tick(0, '0, 0, 1, ch, g, 1);
  endtask

  exp_t hold;
  bit hold_v = 0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) hold_v = 0;
    else begin
      if (hold_v) chk("hold", {m_valid, m_data, m_sat}, {1'b1, hold});
      if (m_valid && m_ready) begin
        chk("beat_expected", 128'(q.size() != 0), 1);
        if (q.size() != 0) chk("beat", {m_data, m_sat}, q.pop_front());
      end
      hold_v = m_valid && !m_ready;
      hold = {m_data, m_sat};
    end
  end

  function automatic logic [NCH*W-1:0] rnd_data();
    logic [NCH*W-1:0] d;
    for (int c = 0; c < NCH; c++) begin
      int k = $urandom_range(0, 5);
      d[c*W +: W] = k == 0 ? 16'h8000 : (k == 1 ? 16'h7fff : 16'($urandom));
    end
    return d;
  endfunction

  initial begin
    logic [NCH*W-1:0] beats [8];
    int i, cyc;
    for (int c = 0; c < NCH; c++) mgain[c] = 8'h10;
    #12;
    chk("rst_state", {m_valid, s_ready, m_data, m_sat}, {1'b0, 1'b1, 68'h0});
    @(negedge clk) rst_n = 1;
    tick(0, '0, 0, 0, 0, 0, 1);
    chk("rst_release_sready", 128'(s_ready), 1);
    cfg(0, 8'h20); cfg(1, 8'h18); cfg(2, 8'h7f);
    send(pk(1000, 0, 0, 0), 0, 0, 0, 0, 1, '{pk(2000, 0, 0, 0), 4'b0000});
    send(pk(0, 3, 0, 0), 0, 0, 0, 0, 1, '{pk(0, 5, 0, 0), 4'b0000});
    send(pk(0, -3, 0, 0), 0, 0, 0, 0, 1, '{pk(0, -4, 0, 0), 4'b0000});
    send(pk(0, 0, 10000, 0), 0, 0, 0, 0, 1, '{pk(0, 0, 32767, 0), 4'b0100});
    send(pk(0, 0, -10000, 0), 0, 0, 0, 0, 1, '{pk(0, 0, -32768, 0), 4'b0100});
    cfg(0, 8'h10); cfg(1, 8'h10);
    send(pk(100, 200, 0, 0), 1, 0, 0, 0, 1, '{pk(-200, 100, 0, 0), 4'b0000});
    send(pk(100, -32768, 0, 0), 1, 0, 0, 0, 1, '{pk(32767, 100, 0, 0), 4'b0001});
    send(pk(50, 0, 0, 0), 0, 1, 0, 8'h20, 1, '{pk(50, 0, 0, 0), 4'b0000});
    send(pk(50, 0, 0, 0), 0, 0, 0, 0, 1, '{pk(100, 0, 0, 0), 4'b0000});
    for (int k = 0; k < 8; k++) beats[k] = rnd_data();
    i = 0; cyc = 0;
    while (i < 8 && cyc < 40) begin
      tick(1, beats[i], 0, 0, 0, 0, !(cyc >= 4 && cyc <= 6));
      if (acc) i++;
      cyc++;
    end
    chk("stream_all_sent", 128'(i), 8);
    for (int k = 0; k < 300; k++)
      tick($urandom_range(0, 3) != 0, rnd_data(), 1'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, NCH - 1), $urandom_range(0, 255), $urandom_range(0, 3) != 0);
    cfg(0, 8'h20);
    send(pk(1, 2, 3, 4), 0, 0, 0, 0, 0, '0);
    send(pk(5, 6, 7, 8), 0, 0, 0, 0, 0, '0);
    @(negedge clk);
    rst_n = 0; s_valid = 0; cfg_we = 0;
    q.delete();
    for (int c = 0; c < NCH; c++) mgain[c] = 8'h10;
    #1;
    chk("midrst_state", {m_valid, s_ready, m_data, m_sat}, {1'b0, 1'b1, 68'h0});
    @(negedge clk) rst_n = 1;
    for (int k = 0; k < 4; k++) tick(0, '0, 0, 0, 0, 0, 1);
    send(pk(1000, -1000, 7, -32768), 0, 0, 0, 0, 1, '{pk(1000, -1000, 7, -32768), 4'b0000});
    for (int k = 0; k < 20 && q.size() != 0; k++) tick(0, '0, 0, 0, 0, 0, 1);
    chk("drain", 128'(q.size()), 0);
    for (int k = 0; k < 4; k++) tick(0, '0, 0, 0, 0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/amp_array.md
AMP_ARRAY -- requirements
Module: amp_array

Interface
REQ-001 Parameter NCH, default 4: channel count; SHALL be even and at least 2, elaboration error otherwise.
REQ-002 Parameter W, default 16: signed sample width per channel.
REQ-003 Parameter GW, default 8: signed gain word width.
REQ-004 Parameter FRAC, default 4: fractional bits of gain word, 1 <= FRAC < GW.
REQ-005 Port clk, input, 1: sole clock, all state updates on rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port s_valid, input, 1: input beat valid.
REQ-008 Port s_ready, output, 1: block accepts input beat.
REQ-009 Port s_data, input, NCH*W: channel c at bits [c*W +: W], two's complement.
REQ-010 Port m_valid, output, 1: output beat valid.
REQ-011 Port m_ready, input, 1: sink accepts output beat.
REQ-012 Port m_data, output, NCH*W: same packing as s_data.
REQ-013 Port m_sat, output, NCH: per-channel saturation flag travelling with m_data.
REQ-014 Port cfg_we, input, 1: gain write strobe.
REQ-015 Port cfg_ch, input, clog2(NCH): gain register index.
REQ-016 Port cfg_gain, input, GW: signed gain, fixed point with FRAC fraction bits.
REQ-017 Port mode, input, 1: 0 = AMP, 1 = GYR; sampled with each accepted beat.

Function
REQ-018 Gain register file SHALL hold NCH signed GW-bit gains, written when cfg_we is high at a clk edge.
REQ-019 AMP mode: y[c] = G[c] * x[c] for every channel c.
REQ-020 GYR mode, per pair (2k, 2k+1): y[2k] = -G[2k] * x[2k+1]; y[2k+1] = G[2k+1] * x[2k].
REQ-021 Negation in GYR mode SHALL be applied to the full-width product, never to the W-bit input, so the most negative input is handled correctly.
REQ-022 Product width W+GW+1 signed; add 2^(FRAC-1), then arithmetic shift right by FRAC (round half up toward +inf).
REQ-023 Shifted result outside [-2^(W-1), 2^(W-1)-1] SHALL clamp to the nearer bound and set m_sat[c] for that beat; otherwise m_sat[c] = 0.
REQ-024 Two-stage pipeline: stage 1 registers products, stage 2 registers rounded/saturated result; latency exactly 2 cycles from s_valid&&s_ready to m_valid with m_ready held high.
REQ-025 Global advance enable en = !m_valid || m_ready; s_ready = en; both stages advance only when en is high.
REQ-026 Throughput one beat per cycle when m_ready is held high.
REQ-027 While m_valid && !m_ready, m_data and m_sat SHALL hold stable and no beat SHALL be lost or duplicated.
REQ-028 Stage 1 SHALL capture gains and mode at beat acceptance; a cfg write in the same cycle as acceptance SHALL NOT affect that beat, only beats accepted later.
REQ-029 Beats already in the pipeline SHALL be unaffected by later cfg writes or mode changes.
REQ-030 Bubbles (s_valid low while en high) SHALL propagate as invalid stages; m_valid deasserts when a bubble reaches stage 2.

Reset
REQ-031 On rst_n low: m_valid = 0, stage-1 valid = 0, m_data = 0, m_sat = 0, all gains = 2^FRAC (unity); s_ready = 1 one cycle after rst_n rises and at all times during reset.
REQ-032 Reset asserted mid-stream SHALL discard all in-flight beats; no beat accepted before reset SHALL appear after it.

Structure
REQ-033 Package amp_array_pkg SHALL hold the mode enum (AMP, GYR) and the rounding/saturation function.
REQ-034 One sub-module, amp_array_sat, SHALL implement round-and-clamp for one channel, instantiated NCH times.

Verification (NCH=4, W=16, GW=8, FRAC=4)
REQ-035 AMP, G[0]=0x20 (2.0), x0=1000, m_ready=1 -> y0=2000 two cycles after acceptance, m_sat[0]=0.
REQ-036 AMP, G[1]=0x18 (1.5), x1=3 then x1=-3 -> y1=5 then y1=-4.
REQ-037 AMP, G[2]=0x7F, x2=10000 -> y2=32767, m_sat[2]=1; x2=-10000 -> y2=-32768, m_sat[2]=1.
REQ-038 GYR, G[0]=G[1]=0x10, x0=100, x1=200 -> y0=-200, y1=100; x1=-32768 -> y0=32767 with m_sat[0]=1.
REQ-039 Stream 8 beats, m_ready low 3 cycles mid-stream -> s_ready low, m_data held, all 8 beats out in order once.
REQ-040 Reset pulse with 2 beats in flight -> m_valid=0, no stale beat emitted, gains return to 0x10.
